// File: rtl/s_axis_cc_pkt_fifo.sv
// rtl/s_axis_cc_pkt_fifo.sv - store-and-forward CC TLP buffer in front of the core s_axis_cc port
// Optional discard of discontinued TLPs: `S_AXIS_CC_PKT_FIFO_DROP_EN
module s_axis_cc_pkt_fifo #(
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = DATA_WIDTH / 32,
  parameter int DEPTH      = 64,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  user_clk,
  input  logic                  user_reset,
  input  logic [DATA_WIDTH-1:0] s_axis_cc_tdata_a,
  input  logic [KEEP_WIDTH-1:0] s_axis_cc_tkeep_a,
  input  logic                  s_axis_cc_tlast_a,
  input  logic [32:0]           s_axis_cc_tuser_a,
  input  logic                  s_axis_cc_tvalid_a,
  output logic                  s_axis_cc_tready_a,
  output logic [DATA_WIDTH-1:0] s_axis_cc_tdata_ip,
  output logic [KEEP_WIDTH-1:0] s_axis_cc_tkeep_ip,
  output logic                  s_axis_cc_tlast_ip,
  output logic [32:0]           s_axis_cc_tuser_ip,
  output logic                  s_axis_cc_tvalid_ip,
  input  logic                  s_axis_cc_tready_ip,
  output logic [AW:0]           pkt_cnt,
  output logic [15:0]           drop_cnt
);

  localparam int EW = DATA_WIDTH + KEEP_WIDTH + 1 + 33;

  logic [EW-1:0] mem [DEPTH];

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] wr_commit_q, wr_commit_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] pkt_cnt_q, pkt_cnt_d;
  logic [AW:0] occupancy;
  logic        wr_en;
  logic        rd_en;
  logic        commit;
  logic        drop_tlp;

  // Uncommitted beats count as occupied so a partial TLP can never be overrun.
  assign occupancy          = wr_ptr_q - rd_ptr_q;
  assign s_axis_cc_tready_a = (occupancy != (AW+1)'(DEPTH));
  assign wr_en              = s_axis_cc_tvalid_a & s_axis_cc_tready_a;

  assign {s_axis_cc_tdata_ip, s_axis_cc_tkeep_ip, s_axis_cc_tlast_ip, s_axis_cc_tuser_ip} =
    mem[rd_ptr_q[AW-1:0]];
  assign s_axis_cc_tvalid_ip = (pkt_cnt_q != '0);
  assign rd_en               = s_axis_cc_tvalid_ip & s_axis_cc_tready_ip;
  assign pkt_cnt             = pkt_cnt_q;

`ifdef S_AXIS_CC_PKT_FIFO_DROP_EN
  logic        drop_flag_q, drop_flag_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // The flag covers earlier beats; the current beat's discontinue counts too.
  assign drop_tlp = drop_flag_q | s_axis_cc_tuser_a[0];
  assign drop_cnt = drop_cnt_q;

  always_comb begin
    drop_flag_d = drop_flag_q;
    drop_cnt_d  = drop_cnt_q;
    if (wr_en) begin
      if (s_axis_cc_tlast_a) begin
        drop_flag_d = 1'b0;
        if (drop_tlp && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
      end else begin
        drop_flag_d = drop_tlp;
      end
    end
  end

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      drop_flag_q <= 1'b0;
      drop_cnt_q  <= 16'd0;
    end else begin
      drop_flag_q <= drop_flag_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end
`else
  assign drop_tlp = 1'b0;
  assign drop_cnt = 16'd0;
`endif

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    rd_ptr_d    = rd_ptr_q;
    commit      = 1'b0;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (s_axis_cc_tlast_a) begin
        if (drop_tlp) begin
          wr_ptr_d = wr_commit_q;
        end else begin
          commit      = 1'b1;
          wr_commit_d = wr_ptr_q + 1'b1;
        end
      end
    end
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    // A commit and a last-beat read-out in the same cycle cancel.
    pkt_cnt_d = pkt_cnt_q + (AW+1)'(commit) - (AW+1)'(rd_en & s_axis_cc_tlast_ip);
  end

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      rd_ptr_q    <= '0;
      pkt_cnt_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      rd_ptr_q    <= rd_ptr_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

  always_ff @(posedge user_clk) begin
    if (wr_en) begin
      mem[wr_ptr_q[AW-1:0]] <= {s_axis_cc_tdata_a, s_axis_cc_tkeep_a,
                                s_axis_cc_tlast_a, s_axis_cc_tuser_a};
    end
  end

  // A full buffer with nothing committed means a TLP longer than DEPTH: deadlock.
  a_no_oversize_tlp: assert property (@(posedge user_clk) disable iff (user_reset)
    !(occupancy == (AW+1)'(DEPTH) && pkt_cnt_q == '0));

endmodule
